// File: rtl/serial_ctrl.sv
// rtl/serial_ctrl.sv - single-wire half-duplex serial control register block
// Framed commands shift data in, latch it to bit_out, or shift it back out on the same pin.
module serial_ctrl #(
  parameter int DATA_LEN = 8,
  parameter int CMD_LEN  = 3
) (
  input  logic                clk,
  input  logic                rst,
  inout  wire                 data_inout,
  output logic [DATA_LEN-1:0] bit_out
);

  typedef enum logic [CMD_LEN-1:0] {
    NOP_CMD       = CMD_LEN'(0),
    RESET_CMD     = CMD_LEN'(1),
    START_RCV_CMD = CMD_LEN'(2),
    UPDATE_CMD    = CMD_LEN'(3),
    START_SND_CMD = CMD_LEN'(4)
  } ctrl_cmd_t;

  typedef enum logic [2:0] {
    IDLE_ST,
    CMD_ST,
    RESET_ST,
    RCV_DATA_ST,
    UPDATE_ST,
    SND_DATA_ST
  } state_t;

  localparam int CNT_W  = $clog2(DATA_LEN + 4);
  localparam int SND_TA = 3;

  state_t              curr_state_q;
  logic [CMD_LEN-1:0]  cmd_q;
  logic [DATA_LEN-1:0] shift_q;
  logic [DATA_LEN-1:0] bit_out_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                oe_q;
  logic                dout_q;
  logic                din;

  assign din        = data_inout;
  assign data_inout = oe_q ? dout_q : 1'bz;
  assign bit_out    = bit_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      curr_state_q <= IDLE_ST;
      cmd_q        <= '0;
      shift_q      <= '0;
      bit_out_q    <= '0;
      cnt_q        <= '0;
      oe_q         <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      case (curr_state_q)
        IDLE_ST, RESET_ST, UPDATE_ST: begin
          if (din) begin
            curr_state_q <= CMD_ST;
            cnt_q        <= '0;
          end
        end
        CMD_ST: begin
          if (cnt_q < CNT_W'(CMD_LEN)) begin
            cmd_q <= {cmd_q[CMD_LEN-2:0], din};
            cnt_q <= cnt_q + 1'b1;
          end else begin
            // Stop-bit edge: decode, with entry actions taken on this same edge
            cnt_q <= '0;
            case (cmd_q)
              RESET_CMD: begin
                curr_state_q <= RESET_ST;
                shift_q      <= '0;
                bit_out_q    <= '0;
              end
              START_RCV_CMD: curr_state_q <= RCV_DATA_ST;
              UPDATE_CMD: begin
                curr_state_q <= UPDATE_ST;
                bit_out_q    <= shift_q;
              end
              START_SND_CMD: curr_state_q <= SND_DATA_ST;
              default:       curr_state_q <= IDLE_ST;
            endcase
          end
        end
        RCV_DATA_ST: begin
          if (cnt_q == '0) begin
            cnt_q <= 1'b1;
          end else begin
            shift_q <= {shift_q[DATA_LEN-2:0], din};
            if (cnt_q == CNT_W'(DATA_LEN)) begin
              curr_state_q <= IDLE_ST;
              cnt_q        <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        SND_DATA_ST: begin
          if (cnt_q < CNT_W'(SND_TA)) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (cnt_q < CNT_W'(SND_TA + DATA_LEN)) begin
            // Rotate so shift_q is back to its original value after the last bit
            oe_q    <= 1'b1;
            dout_q  <= shift_q[DATA_LEN-1];
            shift_q <= {shift_q[DATA_LEN-2:0], shift_q[DATA_LEN-1]};
            cnt_q   <= cnt_q + 1'b1;
          end else begin
            oe_q         <= 1'b0;
            dout_q       <= 1'b0;
            curr_state_q <= IDLE_ST;
            cnt_q        <= '0;
          end
        end
        default: curr_state_q <= IDLE_ST;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ctrl.sv
// tb/tb_serial_ctrl.sv - randomized self-checking bench for serial_ctrl
// Drives command frames as the master and checks bit_out and readback against a transaction model.
module tb_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_oe = 1'b1;
  logic       m_dout = 1'b0;
  wire        line;
  logic [7:0] bit_out;

  int errors = 0;
  int checks = 0;

  // Model state: what the register and the latch must hold after each transaction
  logic [7:0] m_shift = 8'h00;
  logic [7:0] m_bitout = 8'h00;

  assign line = m_oe ? m_dout : 1'bz;
  pulldown (line);

  always #5 clk = ~clk;

  serial_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .data_inout(line),
    .bit_out   (bit_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    m_dout = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [2:0] cmd);
    send_bit(1'b1);
    for (int i = 2; i >= 0; i--) send_bit(cmd[i]);
    send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic op_rcv(input logic [7:0] d, input int nbits);
    send_frame(3'b010);
    send_bit(1'($urandom_range(0, 1)));
    for (int i = 7; i > 7 - nbits; i--) send_bit(d[i]);
    if (nbits == 8) m_shift = d;
  endtask

  task automatic op_update();
    send_frame(3'b011);
    m_bitout = m_shift;
    check_eq("update bit_out", bit_out, m_bitout);
  endtask

  task automatic op_reset_cmd();
    send_frame(3'b001);
    m_shift  = 8'h00;
    m_bitout = 8'h00;
    check_eq("reset_cmd bit_out", bit_out, m_bitout);
  endtask

  task automatic op_nop();
    logic [2:0] codes [4];
    codes[0] = 3'b000; codes[1] = 3'b101; codes[2] = 3'b110; codes[3] = 3'b111;
    send_frame(codes[$urandom_range(0, 3)]);
    check_eq("nop bit_out", bit_out, m_bitout);
  endtask

  task automatic op_snd();
    logic [7:0] got;
    send_frame(3'b100);
    m_oe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("snd turnaround z", line, 1'b0);
    end
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      got[i] = line;
    end
    check_eq("snd data", got, m_shift);
    @(negedge clk);
    check_eq("snd release z", line, 1'b0);
    m_dout = 1'b0;
    m_oe   = 1'b1;
  endtask

  task automatic hard_reset();
    rst    = 1'b1;
    m_dout = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    m_shift  = 8'h00;
    m_bitout = 8'h00;
    check_eq("rst bit_out", bit_out, m_bitout);
  endtask

  initial begin
    m_oe = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset bit_out", bit_out, 8'h00);
    check_eq("reset line z", line, 1'b0);
    rst  = 1'b0;
    m_oe = 1'b1;
    send_bit(1'b0);

    // Directed sequence
    op_reset_cmd();
    repeat (3) send_bit(1'b0);
    check_eq("reset_st hold", bit_out, 8'h00);
    op_rcv(8'h8B, 8);
    check_eq("rcv no latch", bit_out, 8'h00);
    op_update();
    check_eq("update 8B", bit_out, 8'h8B);
    op_snd();
    op_snd();
    op_rcv(8'hB5, 4);
    hard_reset();
    op_update();
    check_eq("update after rst", bit_out, 8'h00);
    op_snd();

    // Random transactions, with 0..2 idle cycles between frames
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0, 5:    op_rcv(8'($urandom), 8);
        1:       op_update();
        2:       op_snd();
        3:       op_reset_cmd();
        4:       op_nop();
        default: hard_reset();
      endcase
      repeat ($urandom_range(0, 2)) send_bit(1'b0);
      check_eq("idle bit_out", bit_out, m_bitout);
    end
    op_update();
    op_snd();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
